// File: rtl/sm_alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sm_alu_pkg
//  Purpose  : Shared definitions for the sign-magnitude mantissa datapath.
//             - operation encodings for the resolved add/sub
//             - elaboration-time clog2 helper used to size count outputs
//             - effective-operation decode from {sign_a, symbol, sign_b}
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package sm_alu_pkg;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   // Ceiling log2, usable in parameter expressions. clog2(1) = 0.
   // The loop stops at bit 30 so the signed shift never goes negative.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

   // A subtraction of like signs, or an addition of unlike signs, is a
   // magnitude subtraction; everything else adds magnitudes.
   function automatic logic eff_op(input logic sign_a,
                                   input logic symbol,
                                   input logic sign_b);
      return sign_a ^ symbol ^ sign_b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sm_lzc.sv
`default_nettype none
// ============================================================================
//  Module   : sm_lzc
//  Purpose  : Combinational leading-zero counter. All-zero input returns N.
//  Ports    : in  [N-1:0]      value to scan (bit N-1 is the MSB)
//             cnt [OUT_W-1:0]  number of zeros above the highest set bit
//  Revision : 1.0  initial release
// ============================================================================
module sm_lzc
   import sm_alu_pkg::*;
#(
   parameter int N     = 25,
   parameter int OUT_W = clog2(N + 1)
) (
   input  logic [N-1:0]     in,
   output logic [OUT_W-1:0] cnt
);

   logic [OUT_W-1:0] w_cnt;

   // Scan upward so the highest set bit is the last one to write the count.
   always_comb begin
      w_cnt = OUT_W'(N);
      for (int i = 0; i < N; i++) begin
         if (in[i]) w_cnt = OUT_W'(N - 1 - i);
      end
   end

   assign cnt = w_cnt;

endmodule
`default_nettype wire

// File: rtl/sm_addsub_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : sm_addsub_pipe
//  Purpose  : Two-stage sign-magnitude mantissa adder/subtractor with
//             valid/ready on both sides, one op per cycle.
//             Stage 1 registers sum, both differences and decoded op;
//             stage 2 picks the magnitude, resolves sign/zero, counts LZ.
//  Ports    : clk, rst_n              clock, synchronous active-low reset
//             in_valid / in_ready     input handshake
//             a, b [W-1:0]            aligned magnitudes
//             sign_a, sign_b, symbol  operand signs, 0 = A+B / 1 = A-B
//             rm_neg                  sign given to an exact-zero difference
//             in_tag / out_tag        opaque tag carried with the op
//             out_valid / out_ready   output handshake
//             out [W:0]               magnitude, bit W = carry of addition
//             sign_out, zero, lzc     sign, out==0, leading zeros of out
//  Revision : 1.0  initial release
// ============================================================================
module sm_addsub_pipe
   import sm_alu_pkg::*;
#(
   parameter int W     = 24,
   parameter int TAG_W = 4,
   parameter int LZC_W = clog2(W + 2)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     a,
   input  logic [W-1:0]     b,
   input  logic             sign_a,
   input  logic             sign_b,
   input  logic             symbol,
   input  logic             rm_neg,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W:0]       out,
   output logic             sign_out,
   output logic             zero,
   output logic [LZC_W-1:0] lzc,
   output logic [TAG_W-1:0] out_tag
);

   // ---------------- handshake ----------------
   logic w_adv1, w_adv2, w_accept;
   logic r_v1, r_v2;

   assign w_adv2   = !r_v2 || out_ready;
   assign w_adv1   = !r_v1 || w_adv2;
   assign w_accept = in_valid && w_adv1;
   assign in_ready = w_adv1;

   // ---------------- stage 1 ----------------
   logic [W:0]       w_sum, w_diff_ab;
   logic [W-1:0]     w_diff_ba;
   logic [W:0]       r_sum, r_diff_ab;
   logic [W-1:0]     r_diff_ba;
   logic             r_eff_sub, r_sign_a, r_rm_neg;
   logic [TAG_W-1:0] r_tag1;

   // Bit W of the extended a-b is the borrow, i.e. b > a.
   assign w_sum     = {1'b0, a} + {1'b0, b};
   assign w_diff_ab = {1'b0, a} - {1'b0, b};
   assign w_diff_ba = b - a;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_v1      <= 1'b0;
         r_sum     <= '0;
         r_diff_ab <= '0;
         r_diff_ba <= '0;
         r_eff_sub <= 1'b0;
         r_sign_a  <= 1'b0;
         r_rm_neg  <= 1'b0;
         r_tag1    <= '0;
      end else if (w_adv1) begin
         r_v1 <= w_accept;
         if (w_accept) begin
            r_sum     <= w_sum;
            r_diff_ab <= w_diff_ab;
            r_diff_ba <= w_diff_ba;
            r_eff_sub <= eff_op(sign_a, symbol, sign_b);
            r_sign_a  <= sign_a;
            r_rm_neg  <= rm_neg;
            r_tag1    <= in_tag;
         end
      end
   end

   // ---------------- stage 2 ----------------
   logic             w_borrow, w_zero, w_sign;
   logic [W:0]       w_mag;
   logic [LZC_W-1:0] w_lzc;

   assign w_borrow = r_diff_ab[W];

   always_comb begin
      w_mag = r_sum;
      if (r_eff_sub == OP_SUB) begin
         w_mag = w_borrow ? {1'b0, r_diff_ba} : {1'b0, r_diff_ab[W-1:0]};
      end
   end

   assign w_zero = (w_mag == '0);

   // Only an exact cancellation takes its sign from the rounding mode; a
   // zero sum of two zero magnitudes keeps the sign of A.
   always_comb begin
      w_sign = r_sign_a;
      if (r_eff_sub == OP_SUB) begin
         w_sign = w_zero ? r_rm_neg : (r_sign_a ^ w_borrow);
      end
   end

   sm_lzc #(.N(W + 1), .OUT_W(LZC_W)) u_lzc (
      .in  (w_mag),
      .cnt (w_lzc)
   );

   logic [W:0]       r_out;
   logic             r_sign_out, r_zero;
   logic [LZC_W-1:0] r_lzc;
   logic [TAG_W-1:0] r_out_tag;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_v2       <= 1'b0;
         r_out      <= '0;
         r_sign_out <= 1'b0;
         r_zero     <= 1'b0;
         r_lzc      <= '0;
         r_out_tag  <= '0;
      end else if (w_adv2) begin
         r_v2 <= r_v1;
         if (r_v1) begin
            r_out      <= w_mag;
            r_sign_out <= w_sign;
            r_zero     <= w_zero;
            r_lzc      <= w_lzc;
            r_out_tag  <= r_tag1;
         end
      end
   end

   assign out_valid = r_v2;
   assign out       = r_out;
   assign sign_out  = r_sign_out;
   assign zero      = r_zero;
   assign lzc       = r_lzc;
   assign out_tag   = r_out_tag;

endmodule
`default_nettype wire
